// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared constants, state encoding and index helper for the VGA plot arbiter
package vga_arb_pkg;

   localparam int NUM_REQ_DEFAULT = 4;
   localparam int X_W             = 8;
   localparam int Y_W             = 7;
   localparam int COLOUR_W        = 3;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   localparam int REQ_SCREEN  = 0;
   localparam int REQ_MAZE    = 1;
   localparam int REQ_SPECIAL = 2;
   localparam int REQ_PLAYER  = 3;

   // Circular index step used by round-robin scans.
   function automatic int wrapInc(input int idx, input int step, input int n);
      return (idx + step) % n;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick of the first request after rrPtr
module rr_priority_select
   import vga_arb_pkg::*;
#(
   parameter int N     = NUM_REQ_DEFAULT,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rrPtr,
   output logic             valid,
   output logic [PTR_W-1:0] winner,
   output logic [N-1:0]     oneHot
);

   logic [N-1:0] mask;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      oneHot = '0;
      mask   = '0;
      // Scan farthest-first so the nearest request after rrPtr is the final write.
      for (int k = N; k >= 1; k--) begin
         mask = N'(1) << wrapInc(int'(rrPtr), k, N);
         if (|(req & mask)) begin
            valid  = 1'b1;
            winner = PTR_W'(wrapInc(int'(rrPtr), k, N));
            oneHot = mask;
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - burst-locked round-robin owner of the VGA adapter plot port
module vga_plot_arbiter #(
   parameter int NUM_REQ  = vga_arb_pkg::NUM_REQ_DEFAULT,
   parameter int X_W      = vga_arb_pkg::X_W,
   parameter int Y_W      = vga_arb_pkg::Y_W,
   parameter int COLOUR_W = vga_arb_pkg::COLOUR_W,
   parameter int TIMEOUT  = 1023
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           plot_valid,
   input  logic [NUM_REQ-1:0]           last,
   input  logic [NUM_REQ*X_W-1:0]       x_in,
   input  logic [NUM_REQ*Y_W-1:0]       y_in,
   input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         busy,
   output logic [X_W-1:0]               vga_x,
   output logic [Y_W-1:0]               vga_y,
   output logic [COLOUR_W-1:0]          vga_colour,
   output logic                         vga_plot,
   output logic                         timeout_err
);

   import vga_arb_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   logic [0:0]         state;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   rrPtr;
   logic [WD_W-1:0]    wdCount;

   logic               selValid;
   logic [PTR_W-1:0]   selWinner;
   logic [NUM_REQ-1:0] selOneHot;

   logic               ownPlot;
   logic               ownLast;
   logic               ownReq;
   logic               forward;
   logic               normalRel;
   logic               abortRel;
   logic               wdExpire;
   logic               releaseNow;

   rr_priority_select #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) uSelect (
      .req    (req),
      .rrPtr  (rrPtr),
      .valid  (selValid),
      .winner (selWinner),
      .oneHot (selOneHot)
   );

   assign ownPlot = plot_valid[owner];
   assign ownLast = last[owner];
   assign ownReq  = req[owner];

   // A last pixel is forwarded even if req falls in the same cycle.
   assign forward    = ownPlot && (ownLast || ownReq);
   assign normalRel  = ownPlot && ownLast;
   assign abortRel   = !ownReq && !normalRel;
   assign wdExpire   = ownReq && !ownPlot && (wdCount == WD_W'(TIMEOUT - 1));
   assign releaseNow = normalRel || abortRel || wdExpire;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= '0;
         rrPtr       <= PTR_W'(NUM_REQ - 1);
         wdCount     <= '0;
         grant       <= '0;
         busy        <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
         vga_plot    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               vga_plot <= 1'b0;
               if (selValid) begin
                  state   <= OWN;
                  owner   <= selWinner;
                  grant   <= selOneHot;
                  busy    <= 1'b1;
                  wdCount <= '0;
               end
            end
            OWN: begin
               vga_plot <= forward;
               if (forward) begin
                  vga_x      <= x_in[int'(owner)*X_W +: X_W];
                  vga_y      <= y_in[int'(owner)*Y_W +: Y_W];
                  vga_colour <= colour_in[int'(owner)*COLOUR_W +: COLOUR_W];
               end
               // Every release passes through IDLE, so grant always drops for a cycle.
               if (releaseNow) begin
                  state       <= IDLE;
                  grant       <= '0;
                  busy        <= 1'b0;
                  rrPtr       <= owner;
                  wdCount     <= '0;
                  timeout_err <= wdExpire;
               end else if (ownPlot) begin
                  wdCount <= '0;
               end else begin
                  wdCount <= wdCount + WD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed plus randomized bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;
   localparam int TO = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    plotValid = '0;
   logic [N-1:0]    last = '0;
   logic [N*XW-1:0] xIn = '0;
   logic [N*YW-1:0] yIn = '0;
   logic [N*CW-1:0] cIn = '0;
   logic [N-1:0]    grant;
   logic            busy;
   logic [XW-1:0]   vgaX;
   logic [YW-1:0]   vgaY;
   logic [CW-1:0]   vgaColour;
   logic            vgaPlot;
   logic            timeoutErr;

   vga_plot_arbiter #(
      .NUM_REQ  (N),
      .X_W      (XW),
      .Y_W      (YW),
      .COLOUR_W (CW),
      .TIMEOUT  (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .plot_valid  (plotValid),
      .last        (last),
      .x_in        (xIn),
      .y_in        (yIn),
      .colour_in   (cIn),
      .grant       (grant),
      .busy        (busy),
      .vga_x       (vgaX),
      .vga_y       (vgaY),
      .vga_colour  (vgaColour),
      .vga_plot    (vgaPlot),
      .timeout_err (timeoutErr)
   );

   always #5 clock = ~clock;

   int assertsDone = 0;
   int failures    = 0;

   // Reference: who owns the port, who was last served, how long the owner has been silent.
   int           mOwner  = -1;
   int           mLast   = N - 1;
   int           mSilent = 0;
   logic [N-1:0] eGrant  = '0;
   logic         eBusy   = 1'b0;
   logic         ePlot   = 1'b0;
   logic         eErr    = 1'b0;
   logic [XW-1:0] eX     = '0;
   logic [YW-1:0] eY     = '0;
   logic [CW-1:0] eC     = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertsDone++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOwner = -1; mLast = N - 1; mSilent = 0;
      eGrant = '0; eBusy = 1'b0; ePlot = 1'b0; eErr = 1'b0;
      eX = '0; eY = '0; eC = '0;
   endtask

   task automatic modelRelease(input int o);
      mLast = o; mOwner = -1; mSilent = 0;
   endtask

   task automatic modelUpdate();
      int o;
      bit pv, lt, rq, found;
      eErr = 1'b0;
      if (mOwner < 0) begin
         ePlot = 1'b0;
         found = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (mLast + k) % N;
            if (!found && req[c]) begin
               found = 1; mOwner = c; mSilent = 0;
            end
         end
      end else begin
         o  = mOwner;
         pv = plotValid[o]; lt = last[o]; rq = req[o];
         ePlot = pv && (lt || rq);
         if (ePlot) begin
            eX = xIn[o*XW +: XW]; eY = yIn[o*YW +: YW]; eC = cIn[o*CW +: CW];
            mSilent = 0;
         end
         if (pv && lt) modelRelease(o);
         else if (!rq) modelRelease(o);
         else if (!pv) begin
            mSilent++;
            if (mSilent == TO) begin
               eErr = 1'b1;
               modelRelease(o);
            end
         end
      end
      eGrant = (mOwner < 0) ? '0 : (N'(1) << mOwner);
      eBusy  = (mOwner >= 0);
   endtask

   task automatic checkAll();
      check("grant",       32'(grant),      32'(eGrant));
      check("busy",        32'(busy),       32'(eBusy));
      check("vga_plot",    32'(vgaPlot),    32'(ePlot));
      check("timeout_err", 32'(timeoutErr), 32'(eErr));
      check("vga_x",       32'(vgaX),       32'(eX));
      check("vga_y",       32'(vgaY),       32'(eY));
      check("vga_colour",  32'(vgaColour),  32'(eC));
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
   endtask

   task automatic step();
      modelUpdate();
      @(posedge clock);
      #1;
      checkAll();
   endtask

   task automatic setPixel(input int e, input int x, input int y, input int c);
      xIn[e*XW +: XW] = XW'(x);
      yIn[e*YW +: YW] = YW'(y);
      cIn[e*CW +: CW] = CW'(c);
   endtask

   task automatic clearInputs();
      req = '0; plotValid = '0; last = '0;
   endtask

   initial begin
      logic [N-1:0] rrExpect [10];
      rrExpect = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

      // Reset values
      @(posedge clock);
      #1;
      modelReset();
      checkAll();
      reset = 1'b0;

      // Round-robin: all engines request, each sends one pixel with last when granted
      req = '1;
      for (int i = 0; i < 10; i++) begin
         plotValid = grant;
         last      = grant;
         for (int e = 0; e < N; e++) setPixel(e, 40 + e, 50 + e, e);
         step();
         check("rr_order", 32'(grant), 32'(rrExpect[i]));
      end
      clearInputs();
      step();

      // Single burst on engine 2
      req = 4'b0100;
      step();
      check("burst_grant", 32'(grant), 32'h4);
      plotValid = 4'b0100; setPixel(2, 10, 20, 5);
      step();
      check("burst_px1_plot", 32'(vgaPlot), 32'd1);
      check("burst_px1_x", 32'(vgaX), 32'd10);
      last = 4'b0100; setPixel(2, 11, 20, 5);
      step();
      check("burst_px2_x", 32'(vgaX), 32'd11);
      check("burst_px2_col", 32'(vgaColour), 32'd5);
      check("burst_release", 32'({grant, busy}), 32'd0);
      clearInputs();
      step();

      // Non-owner isolation: engine 3 strobes x=99 while engine 0 owns
      req = 4'b0001;
      plotValid[3] = 1'b1; setPixel(3, 99, 7, 7);
      step();
      check("iso_grant", 32'(grant), 32'h1);
      for (int i = 0; i < 6; i++) begin
         plotValid[0] = 1'($urandom_range(0, 1));
         last[0]      = (i == 5);
         if (i == 5) plotValid[0] = 1'b1;
         setPixel(0, $urandom_range(0, 98), $urandom_range(0, 119), $urandom_range(0, 7));
         step();
         check("iso_no_99", 32'(vgaX == 8'd99), 32'd0);
      end
      clearInputs();
      step();

      // Abort: engine 1 drops req with a non-last pixel pending
      req = 4'b0010;
      step();
      plotValid = 4'b0010; setPixel(1, 30, 31, 2);
      step();
      req = '0; setPixel(1, 77, 78, 3);
      step();
      check("abort_plot", 32'(vgaPlot), 32'd0);
      check("abort_x", 32'(vgaX), 32'd30);
      check("abort_err", 32'(timeoutErr), 32'd0);
      clearInputs();
      step();

      // Watchdog: engine 2 silent for TO cycles while engine 3 waits
      req = 4'b1100;
      step();
      check("wd_grant", 32'(grant), 32'h4);
      for (int i = 1; i <= TO; i++) step();
      check("wd_err", 32'(timeoutErr), 32'd1);
      check("wd_release", 32'(grant), 32'h0);
      req = 4'b1000;
      step();
      check("wd_err_pulse", 32'(timeoutErr), 32'd0);
      check("wd_next_grant", 32'(grant), 32'h8);
      // Engine 3 plots exactly on the threshold cycle: no timeout
      for (int i = 1; i < TO; i++) step();
      plotValid = 4'b1000; setPixel(3, 5, 6, 1);
      step();
      check("wd_plot_wins", 32'(timeoutErr), 32'd0);
      check("wd_still_owned", 32'(grant), 32'h8);
      plotValid = '0;
      for (int i = 0; i < 3; i++) step();
      plotValid = 4'b1000; last = 4'b1000;
      step();
      clearInputs();
      step();

      // Randomized traffic against the reference
      for (int i = 0; i < 400; i++) begin
         for (int e = 0; e < N; e++) begin
            req[e]       = ($urandom_range(0, 3) != 0);
            plotValid[e] = 1'($urandom_range(0, 1));
            last[e]      = ($urandom_range(0, 5) == 0);
            setPixel(e, $urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 7));
         end
         step();
      end
      clearInputs();
      step();
      step();

      // Reset mid-burst while engine 1 owns and plots
      req = 4'b0010;
      step();
      check("rst_owner", 32'(grant), 32'h2);
      plotValid = 4'b0010; setPixel(1, 60, 61, 6);
      step();
      step();
      #2 reset = 1'b1;
      #1;
      check("rst_async_grant", 32'(grant), 32'h0);
      check("rst_async_plot", 32'(vgaPlot), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      modelReset();
      clearInputs();
      #2 reset = 1'b0;
      req = 4'b0011;
      step();
      check("rst_first_winner", 32'(grant), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertsDone, failures);
      $finish;
   end

endmodule
